// File: rtl/renode_axi_burst_addr_gen.sv
// rtl/renode_axi_burst_addr_gen.sv - AXI burst request FIFO and per-beat address generator
// Optional: define RENODE_AXI_4K_BOUNDARY_CHECK_EN to flag INCR bursts crossing a 4 KB page.
module renode_axi_burst_addr_gen #(
  parameter int AddressWidth       = 32,
  parameter int DataWidth          = 32,
  parameter int TransactionIdWidth = 8,
  parameter int QueueDepth         = 2
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [TransactionIdWidth-1:0] req_id,
  input  logic [AddressWidth-1:0]       req_addr,
  input  logic [7:0]                    req_len,
  input  logic [2:0]                    req_size,
  input  logic [1:0]                    req_burst,
  output logic                          beat_valid,
  input  logic                          beat_ready,
  output logic [TransactionIdWidth-1:0] beat_id,
  output logic [AddressWidth-1:0]       beat_addr,
  output logic [7:0]                    beat_index,
  output logic                          beat_last,
  output logic [1:0]                    beat_resp,
  output logic                          busy
);

  localparam int MaxSize = $clog2(DataWidth / 8);
  localparam int PtrW    = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int CntW    = $clog2(QueueDepth + 1);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic { S_IDLE = 1'b0, S_ACTIVE = 1'b1 } state_t;

  state_t state_q, state_d;

  logic [TransactionIdWidth-1:0] q_id    [QueueDepth];
  logic [AddressWidth-1:0]       q_addr  [QueueDepth];
  logic [7:0]                    q_len   [QueueDepth];
  logic [2:0]                    q_size  [QueueDepth];
  logic [1:0]                    q_burst [QueueDepth];
  logic [PtrW-1:0]               wr_ptr, rd_ptr;
  logic [CntW-1:0]               count;
  logic                          full, empty, push, pop, load, advance;

  logic [TransactionIdWidth-1:0] h_id;
  logic [AddressWidth-1:0]       h_addr, h_sz, h_wb, h_lower;
  logic [7:0]                    h_len;
  logic [2:0]                    h_size;
  logic [1:0]                    h_burst;
  logic                          h_illegal, h_page_cross, h_wrap_len_ok, h_unaligned;
`ifdef RENODE_AXI_4K_BOUNDARY_CHECK_EN
  logic [AddressWidth-1:0]       h_last_byte;
`endif

  logic [7:0]                    cur_len;
  logic [AddressWidth-1:0]       cur_sz, wrap_lower, wrap_upper, step_addr, next_addr;
  logic [1:0]                    cur_burst;
  logic                          cur_hold;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(QueueDepth - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  assign full      = (count == CntW'(QueueDepth));
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign beat_valid = (state_q == S_ACTIVE);
  assign busy      = !empty || (state_q == S_ACTIVE);

  // FIFO storage: written only on accepted pushes, contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      q_id[wr_ptr]    <= req_id;
      q_addr[wr_ptr]  <= req_addr;
      q_len[wr_ptr]   <= req_len;
      q_size[wr_ptr]  <= req_size;
      q_burst[wr_ptr] <= req_burst;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  // Decode the head request: legality, wrap window and optional page-cross flag
  always_comb begin
    h_id          = q_id[rd_ptr];
    h_addr        = q_addr[rd_ptr];
    h_len         = q_len[rd_ptr];
    h_size        = q_size[rd_ptr];
    h_burst       = q_burst[rd_ptr];
    h_sz          = AddressWidth'(1) << h_size;
    h_wb          = h_sz * AddressWidth'({1'b0, h_len} + 9'd1);
    h_lower       = h_addr & ~(h_wb - AddressWidth'(1));
    h_wrap_len_ok = (h_len == 8'd1) || (h_len == 8'd3) || (h_len == 8'd7) || (h_len == 8'd15);
    h_unaligned   = (h_addr & (h_sz - AddressWidth'(1))) != '0;
    h_illegal     = (int'(h_size) > MaxSize) || (h_burst == 2'b11) ||
                    ((h_burst == BurstWrap) && (!h_wrap_len_ok || h_unaligned));
`ifdef RENODE_AXI_4K_BOUNDARY_CHECK_EN
    h_last_byte   = (h_addr & ~(h_sz - AddressWidth'(1))) + h_wb - AddressWidth'(1);
    h_page_cross  = (h_burst == BurstIncr) && ((h_last_byte >> 12) != (h_addr >> 12));
`else
    h_page_cross  = 1'b0;
`endif
  end

  // Address of the following beat; illegal and FIXED bursts hold their address
  always_comb begin
    step_addr = beat_addr + cur_sz;
    next_addr = beat_addr;
    if (!cur_hold) begin
      case (cur_burst)
        BurstIncr: next_addr = (beat_addr & ~(cur_sz - AddressWidth'(1))) + cur_sz;
        BurstWrap: next_addr = (step_addr == wrap_upper) ? wrap_lower : step_addr;
        default:   next_addr = beat_addr;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: pop/load a request when idle or right after a final beat
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_ACTIVE;
          pop     = 1'b1;
          load    = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (beat_ready) begin
          if (beat_last) begin
            if (!empty) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Beat registers: load from the FIFO head or step to the next beat
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      beat_id    <= '0;
      beat_addr  <= '0;
      beat_index <= '0;
      beat_last  <= 1'b0;
      beat_resp  <= RespOkay;
      cur_len    <= '0;
      cur_sz     <= '0;
      cur_burst  <= BurstFixed;
      cur_hold   <= 1'b0;
      wrap_lower <= '0;
      wrap_upper <= '0;
    end else if (load) begin
      beat_id    <= h_id;
      beat_addr  <= h_addr;
      beat_index <= '0;
      beat_last  <= (h_len == 8'd0);
      beat_resp  <= (h_illegal || h_page_cross) ? RespSlverr : RespOkay;
      cur_len    <= h_len;
      cur_sz     <= h_sz;
      cur_burst  <= h_burst;
      cur_hold   <= h_illegal;
      wrap_lower <= h_lower;
      wrap_upper <= h_lower + h_wb;
    end else if (advance) begin
      beat_addr  <= next_addr;
      beat_index <= beat_index + 8'd1;
      beat_last  <= ((beat_index + 8'd1) == cur_len);
    end
  end

endmodule
